// File: rtl/firebird7_in_gate1_tessent_tdr_w19_pkg.sv
// Shared constants and helpers for the firebird7 in_gate1 19-bit TDR.
// The chain constants are also consumed by the ICL/PDL generators and the bench.
package firebird7_in_gate1_tessent_tdr_w19_pkg;

    localparam int TDR_DATA_WIDTH = 19;
    localparam int TDR_CHAIN_LEN  = TDR_DATA_WIDTH + 1;
    localparam int TDR_SEL_IDX    = TDR_DATA_WIDTH;

    // One action per tck edge; IDLE covers deselect and no-enable cycles.
    typedef enum logic [1:0] {
        TDR_IDLE    = 2'd0,
        TDR_CAPTURE = 2'd1,
        TDR_SHIFT   = 2'd2,
        TDR_UPDATE  = 2'd3
    } tdr_op_e;

    // Resolve the enables into a single action: ce beats se beats ue,
    // and nothing happens unless the register is in the active scan path.
    function automatic tdr_op_e tdr_decode(input logic sel, input logic ce,
                                           input logic se, input logic ue);
        tdr_op_e op;
        op = TDR_IDLE;
        if (sel) begin
            if (ce)      op = TDR_CAPTURE;
            else if (se) op = TDR_SHIFT;
            else if (ue) op = TDR_UPDATE;
        end
        return op;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_upd_reg.sv
// TDR update register: loads the shift chain on update, holds otherwise.
// Width-generic so the same cell serves every TDR width in the family.
module firebird7_in_gate1_tessent_tdr_upd_reg #(
    parameter int               WIDTH     = 20,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over load so a reset coincident with ue never half-updates.
    always_ff @(posedge gclk) begin
        if (!grst_n)   q <= RESET_VAL;
        else if (load) q <= d;
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// IJTAG TDR upstream of the 19-bit data mux: capture/shift/update over a
// 20-bit chain (select bit on top, data below). Outputs come straight from
// the update register so the mux select never moves while shifting.
module firebird7_in_gate1_tessent_tdr_w19
    import firebird7_in_gate1_tessent_tdr_w19_pkg::*;
#(
    parameter int                    DATA_WIDTH = TDR_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_si,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] capture_data_in,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  ijtag_select_out
);

    localparam int SEL_IDX = DATA_WIDTH;

    logic [DATA_WIDTH:0] shift_reg;
    tdr_op_e             op;

    assign op = tdr_decode(ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue);

    // Shift chain: capture loads mux output plus the live select bit for
    // readback; shift moves toward bit 0 with si entering at the select end.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_reg <= '0;
        end else begin
            case (op)
                TDR_CAPTURE: shift_reg <= {ijtag_select_out, capture_data_in};
                TDR_SHIFT:   shift_reg <= {ijtag_si, shift_reg[SEL_IDX:1]};
                default:     ;
            endcase
        end
    end

    // Update stage; reset value keeps the mux on the functional path.
    firebird7_in_gate1_tessent_tdr_upd_reg #(
        .WIDTH     (DATA_WIDTH + 1),
        .RESET_VAL ({1'b0, RESET_DATA})
    ) u_upd_reg (
        .gclk   (ijtag_tck),
        .grst_n (ijtag_reset),
        .load   (op == TDR_UPDATE),
        .d      (shift_reg),
        .q      ({ijtag_select_out, ijtag_data_out})
    );

    // Scan out is bit 0 with no retiming stage.
    assign ijtag_so = shift_reg[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv
// Bench for the 19-bit TDR: directed protocol steps followed by random
// enable traffic, all checked against a bit-queue model of the chain.
module tb_firebird7_in_gate1_tessent_tdr_w19;
    import firebird7_in_gate1_tessent_tdr_w19_pkg::*;

    localparam int W = TDR_DATA_WIDTH;
    localparam logic [W-1:0] RST_DATA = '0;

    logic         tck = 1'b0;
    logic         rst_n, sel, si, ce, se, ue;
    logic         so;
    logic [W-1:0] cap, data_out;
    logic         select_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: chain as a queue where element 0 is the bit on so.
    bit           mq[$];
    logic [W-1:0] m_data;
    logic         m_sel;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_tdr_w19 #(
        .DATA_WIDTH (W),
        .RESET_DATA (RST_DATA)
    ) dut (
        .ijtag_tck        (tck),
        .ijtag_reset      (rst_n),
        .ijtag_sel        (sel),
        .ijtag_si         (si),
        .ijtag_ce         (ce),
        .ijtag_se         (se),
        .ijtag_ue         (ue),
        .ijtag_so         (so),
        .capture_data_in  (cap),
        .ijtag_data_out   (data_out),
        .ijtag_select_out (select_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one tck edge, written from the protocol rules.
    task automatic model_edge();
        if (!rst_n) begin
            mq.delete();
            for (int i = 0; i < TDR_CHAIN_LEN; i++) mq.push_back(1'b0);
            m_data = RST_DATA;
            m_sel  = 1'b0;
        end else if (sel) begin
            if (ce) begin
                mq.delete();
                for (int i = 0; i < W; i++) mq.push_back(cap[i]);
                mq.push_back(m_sel);
            end else if (se) begin
                void'(mq.pop_front());
                mq.push_back(si);
            end else if (ue) begin
                for (int i = 0; i < W; i++) m_data[i] = mq[i];
                m_sel = mq[TDR_SEL_IDX];
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, check just after it.
    task automatic cyc(input logic r, input logic s, input logic c, input logic sh,
                       input logic u, input logic d, input logic [W-1:0] cv);
        rst_n = r; sel = s; ce = c; se = sh; ue = u; si = d; cap = cv;
        @(posedge tck);
        model_edge();
        #1;
        chk("so", {31'b0, so}, {31'b0, mq[0]});
        chk("data_out", {13'b0, data_out}, {13'b0, m_data});
        chk("select_out", {31'b0, select_out}, {31'b0, m_sel});
    endtask

    initial begin
        logic [TDR_CHAIN_LEN-1:0] pat;
        logic so_hold;
        for (int i = 0; i < TDR_CHAIN_LEN; i++) mq.push_back(1'b0);
        m_data = RST_DATA;
        m_sel  = 1'b0;

        // 1. reset for two cycles
        cyc(0, 0, 0, 0, 0, 0, '0);
        cyc(0, 1, 1, 1, 1, 1, 19'h12345);
        chk("rst_select", {31'b0, select_out}, 32'h0);
        chk("rst_data", {13'b0, data_out}, 32'h0);
        chk("rst_so", {31'b0, so}, 32'h0);

        // 2. load override {1, 5A5A5} LSB-first, then update
        pat = {1'b1, 19'h5A5A5};
        for (int i = 0; i < TDR_CHAIN_LEN; i++) begin
            cyc(1, 1, 0, 1, 0, pat[i], '0);
            chk("load_hold_sel", {31'b0, select_out}, 32'h0);
        end
        cyc(1, 1, 0, 0, 1, 0, '0);
        chk("load_data", {13'b0, data_out}, 32'h5A5A5);
        chk("load_sel", {31'b0, select_out}, 32'h1);

        // 3. capture all-ones with select=1, then read back 20 bits
        cyc(1, 1, 1, 0, 0, 0, 19'h7FFFF);
        chk("rb_bit0", {31'b0, so}, 32'h1);
        for (int i = 1; i < TDR_CHAIN_LEN; i++) begin
            cyc(1, 1, 0, 1, 0, 0, '0);
            chk("rb_bit", {31'b0, so}, 32'h1);
        end
        cyc(1, 1, 0, 1, 0, 0, '0);

        // 4. deselected: enables toggle, nothing moves
        so_hold = so;
        for (int i = 0; i < 30; i++) begin
            cyc(1, 0, i[0], i[1], i[2], 1, 19'h2AAAA);
            chk("desel_so", {31'b0, so}, {31'b0, so_hold});
        end
        chk("desel_data", {13'b0, data_out}, 32'h5A5A5);

        // 5. priority: ce+se captures only; se+ue shifts only
        cyc(1, 1, 1, 1, 0, 0, 19'h00003);
        chk("pri_cap_so", {31'b0, so}, 32'h1);
        cyc(1, 1, 0, 1, 1, 0, '0);
        chk("pri_shift_so", {31'b0, so}, 32'h1);
        chk("pri_no_upd", {13'b0, data_out}, 32'h5A5A5);

        // 6. reset mid-shift, then update loads zeros
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 1, 0, 1, '0);
        cyc(0, 1, 0, 1, 0, 1, '0);
        chk("midrst_data", {13'b0, data_out}, 32'h0);
        chk("midrst_sel", {31'b0, select_out}, 32'h0);
        cyc(1, 1, 0, 0, 1, 0, '0);
        chk("midrst_upd_data", {13'b0, data_out}, 32'h0);
        chk("midrst_upd_sel", {31'b0, select_out}, 32'h0);

        // Random traffic, occasional reset coincident with anything
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
